// File: rtl/console_writer_pkg.sv
// Shared types and constants for the console writer: FSM states, cursor
// commands and the ASCII control codes the writer interprets.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CLEAR   = 3'd3,
    REFRESH = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_ADVANCE = 3'd1,
    CMD_NEWLINE = 3'd2,
    CMD_CR      = 3'd3,
    CMD_TAB     = 3'd4,
    CMD_BS      = 3'd5,
    CMD_HOME    = 3'd6
  } cursor_cmd_e;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam int         TAB_STOP = 8;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_writer_if.sv
// Character-in / video-memory-out bundle of the console writer.
interface console_writer_if;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        flush;
  logic        vga_write;
  logic [15:0] vga_addr;
  logic [15:0] vga_data;
  logic        vga_clear;
  logic        vga_activate;
  logic [15:0] cursor_row;
  logic [15:0] cursor_col;

  modport master (
    output in_valid, in_char, flush,
    input  in_ready, vga_write, vga_addr, vga_data, vga_clear, vga_activate,
    input  cursor_row, cursor_col
  );

  modport slave (
    input  in_valid, in_char, flush,
    output in_ready, vga_write, vga_addr, vga_data, vga_clear, vga_activate,
    output cursor_row, cursor_col
  );
endinterface

// File: rtl/console_writer_cursor.sv
// Cursor row/column registers with the wrap, newline, tab and backspace
// rules; also produces the linear video address of the current cell.
module console_cursor
  import console_pkg::*;
#(
  parameter int WIDTH  = 150,
  parameter int HEIGHT = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  cursor_cmd_e cmd_i,
  output logic [15:0] row_o,
  output logic [15:0] col_o,
  output logic [15:0] addr_o,
  output logic        wrap_last_o,
  output logic        last_row_o,
  output logic        tab_wrap_o
);

  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam logic [15:0] W16      = 16'(WIDTH);

  logic [15:0] row_q, row_d, col_q, col_d;
  logic [15:0] tab_col_s, next_row_s;

  // A newline from the bottom row homes the cursor; the caller issues the clear.
  always_comb begin
    tab_col_s  = (col_q | 16'(TAB_STOP - 1)) + 16'd1;
    next_row_s = (row_q == LAST_ROW) ? 16'd0 : row_q + 16'd1;
    row_d      = row_q;
    col_d      = col_q;
    case (cmd_i)
      CMD_ADVANCE: begin
        if (col_q == LAST_COL) begin
          col_d = 16'd0;
          row_d = next_row_s;
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      CMD_NEWLINE: begin
        col_d = 16'd0;
        row_d = next_row_s;
      end
      CMD_CR: col_d = 16'd0;
      CMD_TAB: begin
        if (tab_col_s >= W16) begin
          col_d = 16'd0;
          row_d = next_row_s;
        end else begin
          col_d = tab_col_s;
        end
      end
      CMD_BS: begin
        if (col_q != 16'd0) begin
          col_d = col_q - 16'd1;
        end else begin
          col_d = col_q;
        end
      end
      CMD_HOME: begin
        col_d = 16'd0;
        row_d = 16'd0;
      end
      default: begin
        col_d = col_q;
        row_d = row_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 16'd0;
      col_q <= 16'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o       = row_q;
  assign col_o       = col_q;
  assign addr_o      = 16'(row_q * W16) + col_q;
  assign last_row_o  = (row_q == LAST_ROW);
  assign wrap_last_o = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign tab_wrap_o  = (tab_col_s >= W16);

endmodule

// File: rtl/console_writer.sv
// Console writer top: byte acceptance FSM, flush latch and the registered
// write/clear/refresh strobes toward the text-mode video memory.
module console_writer
  import console_pkg::*;
#(
  parameter int WIDTH        = 150,
  parameter int HEIGHT       = 50,
  parameter bit AUTO_REFRESH = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  console_writer_if.slave bus
);

  if (WIDTH * HEIGHT > 65536) begin : g_size_check
    $error("console_writer: WIDTH*HEIGHT does not fit a 16-bit address");
  end

  state_e      state_q, state_d;
  cursor_cmd_e cmd_s;
  logic        flush_pend_q, flush_pend_d;
  logic [7:0]  char_q, char_d;
  logic        advance_q, advance_d;
  logic        refresh_after_q, refresh_after_d;
  logic        setup_first_q, setup_first_d;
  logic        in_ready_q, vga_write_q, vga_clear_q, vga_activate_q;
  logic [15:0] vga_addr_q, vga_data_q;
  logic [15:0] row_s, col_s, addr_s;
  logic        wrap_last_s, last_row_s, tab_wrap_s, accept_s;

  console_cursor #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_i      (cmd_s),
    .row_o      (row_s),
    .col_o      (col_s),
    .addr_o     (addr_s),
    .wrap_last_o(wrap_last_s),
    .last_row_o (last_row_s),
    .tab_wrap_o (tab_wrap_s)
  );

  assign accept_s = bus.in_valid && in_ready_q;

  // A flush arriving in the REFRESH cycle itself stays pending for another pass.
  always_comb begin
    if (bus.flush) begin
      flush_pend_d = 1'b1;
    end else if (state_q == REFRESH) begin
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q;
    end
  end

  // SETUP lasts two cycles: address/data are captured in the first, the
  // second gives the memory a full cycle of setup before the write edge.
  always_comb begin
    state_d         = state_q;
    char_d          = char_q;
    advance_d       = advance_q;
    refresh_after_d = refresh_after_q;
    setup_first_d   = setup_first_q;
    cmd_s           = CMD_NONE;
    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d = REFRESH;
        end else if (accept_s) begin
          if (is_printable(bus.in_char)) begin
            char_d        = bus.in_char;
            advance_d     = 1'b1;
            setup_first_d = 1'b1;
            state_d       = SETUP;
          end else begin
            case (bus.in_char)
              CH_LF: begin
                cmd_s           = CMD_NEWLINE;
                refresh_after_d = AUTO_REFRESH;
                if (last_row_s) begin
                  state_d = CLEAR;
                end else if (AUTO_REFRESH) begin
                  state_d = REFRESH;
                end else begin
                  state_d = IDLE;
                end
              end
              CH_CR: cmd_s = CMD_CR;
              CH_BS: begin
                if (col_s != 16'd0) begin
                  cmd_s         = CMD_BS;
                  char_d        = CH_SPACE;
                  advance_d     = 1'b0;
                  setup_first_d = 1'b1;
                  state_d       = SETUP;
                end else begin
                  cmd_s = CMD_NONE;
                end
              end
              CH_TAB: begin
                cmd_s           = CMD_TAB;
                refresh_after_d = 1'b0;
                if (tab_wrap_s && last_row_s) begin
                  state_d = CLEAR;
                end else begin
                  state_d = IDLE;
                end
              end
              CH_FF: begin
                cmd_s           = CMD_HOME;
                refresh_after_d = AUTO_REFRESH;
                state_d         = CLEAR;
              end
              default: cmd_s = CMD_NONE;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (setup_first_q) begin
          setup_first_d = 1'b0;
        end else begin
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (advance_q) begin
          cmd_s           = CMD_ADVANCE;
          refresh_after_d = 1'b0;
          state_d         = wrap_last_s ? CLEAR : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR:   state_d = refresh_after_q ? REFRESH : IDLE;
      REFRESH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flush_pend_q    <= 1'b0;
      char_q          <= 8'h00;
      advance_q       <= 1'b0;
      refresh_after_q <= 1'b0;
      setup_first_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pend_q    <= flush_pend_d;
      char_q          <= char_d;
      advance_q       <= advance_d;
      refresh_after_q <= refresh_after_d;
      setup_first_q   <= setup_first_d;
    end
  end

  // Strobes decode the next state so each is a clean one-hot registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q     <= 1'b1;
      vga_write_q    <= 1'b0;
      vga_clear_q    <= 1'b0;
      vga_activate_q <= 1'b0;
      vga_addr_q     <= 16'd0;
      vga_data_q     <= 16'd0;
    end else begin
      in_ready_q     <= (state_d == IDLE) && !flush_pend_d;
      vga_write_q    <= (state_d == STROBE);
      vga_clear_q    <= (state_d == CLEAR);
      vga_activate_q <= (state_d == REFRESH);
      if ((state_q == SETUP) && setup_first_q) begin
        vga_addr_q <= addr_s;
        vga_data_q <= {8'h00, char_q};
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.vga_write    = vga_write_q;
  assign bus.vga_addr     = vga_addr_q;
  assign bus.vga_data     = vga_data_q;
  assign bus.vga_clear    = vga_clear_q;
  assign bus.vga_activate = vga_activate_q;
  assign bus.cursor_row   = row_s;
  assign bus.cursor_col   = col_s;

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: a vector table of cursor-position /
// byte / expected-effect records plus hand sequences for timing corners.
module tb_console_writer;
  import console_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  console_writer_if bus();

  console_writer #(.WIDTH(150), .HEIGHT(50), .AUTO_REFRESH(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // strobe monitor, sampled on the falling edge
  int wr_cnt = 0, clr_cnt = 0, act_cnt = 0, cyc = 0;
  int clr_cyc = 0, act_cyc = 0, overlap = 0, long_pulse = 0;
  logic [15:0] wr_addr = 16'd0, wr_data = 16'd0, wr_addr_before = 16'd0, addr_prev = 16'd0;
  logic wr_prev = 1'b0, clr_prev = 1'b0, act_prev = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    wr_prev   <= bus.vga_write;
    clr_prev  <= bus.vga_clear;
    act_prev  <= bus.vga_activate;
    addr_prev <= bus.vga_addr;
    if (bus.vga_write && !wr_prev) begin
      wr_cnt         <= wr_cnt + 1;
      wr_addr        <= bus.vga_addr;
      wr_data        <= bus.vga_data;
      wr_addr_before <= addr_prev;
    end
    if (bus.vga_clear && !clr_prev) begin
      clr_cnt <= clr_cnt + 1;
      clr_cyc <= cyc;
    end
    if (bus.vga_activate && !act_prev) begin
      act_cnt <= act_cnt + 1;
      act_cyc <= cyc;
    end
    if ((32'(bus.vga_write) + 32'(bus.vga_clear) + 32'(bus.vga_activate)) > 32'd1)
      overlap <= overlap + 1;
    if ((bus.vga_write && wr_prev) || (bus.vga_clear && clr_prev) || (bus.vga_activate && act_prev))
      long_pulse <= long_pulse + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", int'(n < 200), 1);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_bound", int'(n < 200), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic goto_pos(input int r, input int c);
    send(CH_FF);
    repeat (r) send(CH_LF);
    repeat (c / 8) send(CH_TAB);
    repeat (c % 8) send(8'h78);
    wait_idle();
  endtask

  typedef struct {
    logic [7:0] ch;
    int r0, c0, er, ec, ew, ea, ed, ecl, eac;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    int bw, bc, ba, ready_low, n;

    //           ch     r0  c0   er ec  wr addr  data  clr act
    vt[0]  = '{8'h41,  0,  0,   0,  1, 1,    0, 'h41, 0, 0};
    vt[1]  = '{8'h5A, 49, 149,  0,  0, 1, 7499, 'h5A, 1, 0};
    vt[2]  = '{CH_BS,  3, 10,   3,  9, 1,  459, 'h20, 0, 0};
    vt[3]  = '{CH_BS,  3,  0,   3,  0, 0,    0,    0, 0, 0};
    vt[4]  = '{CH_TAB, 2, 145,  3,  0, 0,    0,    0, 0, 0};
    vt[5]  = '{CH_TAB, 2,  5,   2,  8, 0,    0,    0, 0, 0};
    vt[6]  = '{CH_LF, 49,  7,   0,  0, 0,    0,    0, 1, 1};
    vt[7]  = '{CH_FF,  5,  5,   0,  0, 0,    0,    0, 1, 1};
    vt[8]  = '{CH_CR,  4, 20,   4,  0, 0,    0,    0, 0, 0};
    vt[9]  = '{CH_LF,  4, 20,   5,  0, 0,    0,    0, 0, 1};
    vt[10] = '{8'h01,  1,  3,   1,  3, 0,    0,    0, 0, 0};
    vt[11] = '{8'h7F,  1,  3,   1,  3, 0,    0,    0, 0, 0};
    vt[12] = '{8'h7E,  0, 149,  1,  0, 1,  149, 'h7E, 0, 0};
    vt[13] = '{CH_TAB,49, 147,  0,  0, 0,    0,    0, 1, 0};
    vt[14] = '{8'h20, 10,  0,  10,  1, 1, 1500, 'h20, 0, 0};

    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_write", int'(bus.vga_write), 0);
    check("rst_clear", int'(bus.vga_clear), 0);
    check("rst_activate", int'(bus.vga_activate), 0);
    check("rst_addr", int'(bus.vga_addr), 0);
    check("rst_data", int'(bus.vga_data), 0);
    check("rst_row", int'(bus.cursor_row), 0);
    check("rst_col", int'(bus.cursor_col), 0);

    // 'A' cycle-by-cycle: accept edge, setup, strobe, ready again
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h41;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ready_low = 0;
    @(negedge clk);
    ready_low += int'(!bus.in_ready);
    check("A_c1_write", int'(bus.vga_write), 0);
    @(negedge clk);
    ready_low += int'(!bus.in_ready);
    check("A_c2_addr", int'(bus.vga_addr), 0);
    check("A_c2_data", int'(bus.vga_data), 16'h0041);
    check("A_c2_write", int'(bus.vga_write), 0);
    @(negedge clk);
    ready_low += int'(!bus.in_ready);
    check("A_c3_write", int'(bus.vga_write), 1);
    check("A_c3_addr", int'(bus.vga_addr), 0);
    @(negedge clk);
    check("A_c4_write", int'(bus.vga_write), 0);
    check("A_c4_ready", int'(bus.in_ready), 1);
    check("A_ready_low_cycles", ready_low, 3);
    check("A_row", int'(bus.cursor_row), 0);
    check("A_col", int'(bus.cursor_col), 1);

    for (int i = 0; i < NV; i++) begin
      goto_pos(vt[i].r0, vt[i].c0);
      bw = wr_cnt; bc = clr_cnt; ba = act_cnt;
      send(vt[i].ch);
      wait_idle();
      check($sformatf("vec%0d_row", i), int'(bus.cursor_row), vt[i].er);
      check($sformatf("vec%0d_col", i), int'(bus.cursor_col), vt[i].ec);
      check($sformatf("vec%0d_writes", i), wr_cnt - bw, vt[i].ew);
      check($sformatf("vec%0d_clears", i), clr_cnt - bc, vt[i].ecl);
      check($sformatf("vec%0d_activates", i), act_cnt - ba, vt[i].eac);
      if (vt[i].ew > 0) begin
        check($sformatf("vec%0d_addr", i), int'(wr_addr), vt[i].ea);
        check($sformatf("vec%0d_data", i), int'(wr_data), vt[i].ed);
        check($sformatf("vec%0d_addr_setup", i), int'(wr_addr_before), vt[i].ea);
      end
    end

    // a full row of printables wraps to the next row
    goto_pos(0, 0);
    bw = wr_cnt;
    for (int k = 0; k < 150; k++) send(8'h61 + 8'(k % 26));
    wait_idle();
    check("row150_writes", wr_cnt - bw, 150);
    check("row150_last_addr", int'(wr_addr), 149);
    check("row150_row", int'(bus.cursor_row), 1);
    check("row150_col", int'(bus.cursor_col), 0);

    // clear then activate on consecutive cycles for LF at the bottom and FF
    goto_pos(49, 7);
    send(CH_LF);
    wait_idle();
    check("lf_bottom_act_after_clear", act_cyc - clr_cyc, 1);
    goto_pos(8, 3);
    send(CH_FF);
    wait_idle();
    check("ff_act_after_clear", act_cyc - clr_cyc, 1);

    // flush raised during STROBE with in_valid held high
    goto_pos(0, 0);
    bw = wr_cnt; ba = act_cnt;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h42;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("flush_in_strobe_write", int'(bus.vga_write), 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("flush_ready_within_bound", int'(n < 50), 1);
    check("flush_activate_before_next", act_cnt - ba, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_idle();
    check("flush_writes", wr_cnt - bw, 2);
    check("flush_activates_total", act_cnt - ba, 1);
    check("flush_col", int'(bus.cursor_col), 2);

    // reset asserted during SETUP: the write never strobes
    goto_pos(2, 4);
    bw = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h51;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_row", int'(bus.cursor_row), 0);
    check("rst_mid_col", int'(bus.cursor_col), 0);
    check("rst_mid_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_write", wr_cnt - bw, 0);
    check("rst_mid_row_after", int'(bus.cursor_row), 0);
    check("rst_mid_col_after", int'(bus.cursor_col), 0);

    check("strobe_overlap_cycles", overlap, 0);
    check("strobe_multi_cycle_pulses", long_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
